// File: rtl/compressed_word_packer_pkg.sv
// Shared widths, state encoding and length type for the compressed word packer.
package compress_pkg;
  localparam int WORD_SIZE = 64;
  localparam int LEN_W     = 7;
  localparam int CODE_MAX  = (1 << LEN_W) - 1;
  // One bit wider than the 190-bit worst case (63 pending + 127 new bits).
  localparam int BUF_W     = WORD_SIZE + CODE_MAX;
  localparam int FILL_W    = 8;
  localparam int NBITS_W   = 7;
  localparam int LINE_W    = 16;

  localparam logic [FILL_W-1:0]  FILL_WORD  = FILL_W'(WORD_SIZE);
  localparam logic [NBITS_W-1:0] NBITS_FULL = NBITS_W'(WORD_SIZE);

  typedef enum logic {S_ACCUM, S_FLUSH} pack_state_t;
  typedef logic [LEN_W-1:0] code_len_t;
endpackage

// File: rtl/compressed_word_packer_code_align_shifter.sv
// Masks a code to its length and places it at the current fill offset of the pack buffer.
module code_align_shifter
  import compress_pkg::*;
(
  input  logic [CODE_MAX-1:0] i_code,
  input  code_len_t           i_len,
  input  logic [FILL_W-1:0]   i_fill,
  output logic [BUF_W-1:0]    o_shifted
);

  logic [CODE_MAX-1:0] mask;
  logic [CODE_MAX-1:0] masked;

  always_comb begin
    mask = '0;
    // A zero-length code must contribute nothing, so it cannot share the shift form.
    if (i_len != '0) begin
      mask = {CODE_MAX{1'b1}} >> (code_len_t'(CODE_MAX) - i_len);
    end
    masked    = i_code & mask;
    o_shifted = {{(BUF_W-CODE_MAX){1'b0}}, masked} << i_fill;
  end

endmodule

// File: rtl/compressed_word_packer.sv
// Packs variable-length codes LSB-first into WORD_SIZE-bit words; flushes a tagged
// partial word and reports the line's bit count at end of line.
module compressed_word_packer
  import compress_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CODE_MAX-1:0]  i_code,
  input  code_len_t            i_len,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] o_word,
  output logic [NBITS_W-1:0]   o_nbits,
  output logic                 o_last,
  output logic [LINE_W-1:0]    o_line_bits,
  output logic                 o_busy
);

  pack_state_t        state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0]  line_bits_q, line_bits_d;
  logic [BUF_W-1:0]   shifted;
  logic               full;

  code_align_shifter u_shift (
    .i_code    (i_code),
    .i_len     (i_len),
    .i_fill    (fill_q),
    .o_shifted (shifted)
  );

  // Every output is a function of registers only, keeping handshakes free of comb loops.
  assign full        = (fill_q >= FILL_WORD);
  assign o_ready     = (state_q == S_ACCUM) && !full;
  assign o_valid     = full || (state_q == S_FLUSH);
  assign o_word      = buf_q[WORD_SIZE-1:0];
  assign o_nbits     = full ? NBITS_FULL : fill_q[NBITS_W-1:0];
  assign o_last      = (state_q == S_FLUSH) && (fill_q <= FILL_WORD);
  assign o_line_bits = line_bits_q;
  assign o_busy      = (state_q == S_FLUSH) || (fill_q != '0);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    line_cnt_d  = line_cnt_q;
    line_bits_d = line_bits_q;
    if (i_valid && o_ready) begin
      buf_d      = buf_q | shifted;
      fill_d     = fill_q + {1'b0, i_len};
      line_cnt_d = line_cnt_q + LINE_W'(i_len);
      if (i_last) state_d = S_FLUSH;
    end else if (o_valid && i_ready) begin
      buf_d  = buf_q >> WORD_SIZE;
      fill_d = fill_q - {1'b0, o_nbits};
      if (o_last) begin
        state_d     = S_ACCUM;
        fill_d      = '0;
        buf_d       = '0;
        line_bits_d = line_cnt_q;
        line_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_ACCUM;
      buf_q       <= '0;
      fill_q      <= '0;
      line_cnt_q  <= '0;
      line_bits_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      line_cnt_q  <= line_cnt_d;
      line_bits_q <= line_bits_d;
    end
  end

endmodule

// File: tb/tb_compressed_word_packer.sv
// Directed bench with a bit-queue reference model checked every cycle plus literal expectations.
module tb_compressed_word_packer;
  import compress_pkg::*;

  localparam logic [CODE_MAX-1:0] ONES = '1;

  logic                 clk;
  logic                 i_reset = 1'b0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [CODE_MAX-1:0]  i_code = '0;
  code_len_t            i_len = '0;
  logic                 i_last = 1'b0;
  logic                 o_valid;
  logic                 i_ready = 1'b0;
  logic [WORD_SIZE-1:0] o_word;
  logic [NBITS_W-1:0]   o_nbits;
  logic                 o_last;
  logic [LINE_W-1:0]    o_line_bits;
  logic                 o_busy;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Reference model: the pending bitstream of the current line as a plain bit queue.
  bit mpend[$];
  bit mflush;
  int mline;
  int mlinebits;

  compressed_word_packer dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_code      (i_code),
    .i_len       (i_len),
    .i_last      (i_last),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_word      (o_word),
    .o_nbits     (o_nbits),
    .o_last      (o_last),
    .o_line_bits (o_line_bits),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk or negedge i_reset) begin
    int n;
    if (!i_reset) begin
      mpend.delete();
      mflush    = 1'b0;
      mline     = 0;
      mlinebits = 0;
    end else begin
      n = mpend.size();
      if (i_valid && !mflush && n < 64) begin
        for (int i = 0; i < int'(i_len); i++) mpend.push_back(i_code[i]);
        mline += int'(i_len);
        if (i_last) mflush = 1'b1;
      end else if ((n >= 64 || mflush) && i_ready) begin
        if (mflush && n <= 64) begin
          mpend.delete();
          mflush    = 1'b0;
          mlinebits = mline;
          mline     = 0;
        end else begin
          for (int i = 0; i < 64; i++) void'(mpend.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    int n;
    logic [63:0] w;
    if (chk_en) begin
      n = mpend.size();
      w = '0;
      for (int i = 0; i < 64 && i < n; i++) w[i] = mpend[i];
      check("m_ready", o_ready, !mflush && n < 64);
      check("m_valid", o_valid, n >= 64 || mflush);
      check("m_word", o_word, w);
      check("m_nbits", o_nbits, (n >= 64) ? 64 : n);
      check("m_last", o_last, mflush && n <= 64);
      check("m_busy", o_busy, mflush || n != 0);
      check("m_line_bits", o_line_bits, mlinebits);
    end
  end

  task automatic send(input logic [CODE_MAX-1:0] code, input int len, input logic last);
    bit acc = 1'b0;
    bit r;
    i_valid = 1'b1;
    i_code  = code;
    i_len   = code_len_t'(len);
    i_last  = last;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      r = o_ready;
      @(posedge clk);
      #1;
      acc = r;
    end
    i_valid = 1'b0;
    i_code  = '0;
    i_len   = '0;
    i_last  = 1'b0;
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic expect_word(input string nm, input logic [63:0] w, input int nb, input logic last);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = o_valid;
    end
    check({nm, "_valid"}, got, 1'b1);
    check({nm, "_word"}, o_word, w);
    check({nm, "_nbits"}, o_nbits, nb);
    check({nm, "_last"}, o_last, last);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b1;
    chk_en  = 1'b1;

    @(negedge clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_line_bits", o_line_bits, 16'd0);
    check("rst_word", o_word, 64'd0);
    @(posedge clk);
    #1;

    // 40+12+12 ones fill exactly one word, blocking further codes until it drains.
    send(ONES, 40, 1'b0);
    send(ONES, 12, 1'b0);
    send(ONES, 12, 1'b0);
    @(negedge clk);
    check("s2_ready_blocked", o_ready, 1'b0);
    @(posedge clk);
    #1;
    expect_word("s2_w0", 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
    send('0, 24, 1'b0);
    @(negedge clk);
    check("s2_ready_after", o_ready, 1'b1);
    check("s2_valid_after", o_valid, 1'b0);
    check("s2_busy_after", o_busy, 1'b1);
    @(posedge clk);
    #1;
    send(ONES, 0, 1'b1);
    expect_word("s2_tail", 64'd0, 24, 1'b1);
    @(negedge clk);
    check("s2_line_bits", o_line_bits, 16'd88);
    @(posedge clk);
    #1;

    send(ONES, 127, 1'b0);
    expect_word("s3_w0", 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
    send({{(CODE_MAX-4){1'b1}}, 4'hA}, 4, 1'b1);
    expect_word("s3_w1", 64'h7FFF_FFFF_FFFF_FFFF, 64, 1'b0);
    expect_word("s3_w2", 64'h5, 3, 1'b1);
    @(negedge clk);
    check("s3_line_bits", o_line_bits, 16'd131);
    @(posedge clk);
    #1;

    send(ONES, 127, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("s4_hold_valid", o_valid, 1'b1);
      check("s4_hold_ready", o_ready, 1'b0);
      check("s4_hold_word", o_word, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    @(posedge clk);
    #1;
    expect_word("s4_w0", 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
    send('0, 0, 1'b1);
    expect_word("s4_w1", 64'h7FFF_FFFF_FFFF_FFFF, 63, 1'b1);
    @(negedge clk);
    check("s4_line_bits", o_line_bits, 16'd127);
    @(posedge clk);
    #1;

    send(ONES, 0, 1'b1);
    expect_word("s5_empty", 64'd0, 0, 1'b1);
    @(negedge clk);
    check("s5_empty_line_bits", o_line_bits, 16'd0);
    @(posedge clk);
    #1;
    send(ONES, 32, 1'b0);
    send({{(CODE_MAX-32){1'b1}}, 32'h1234_5678}, 32, 1'b1);
    expect_word("s5_align", 64'h1234_5678_FFFF_FFFF, 64, 1'b1);
    @(negedge clk);
    check("s5_no_extra_word", o_valid, 1'b0);
    check("s5_align_line_bits", o_line_bits, 16'd64);
    @(posedge clk);
    #1;

    send(ONES, 67, 1'b1);
    @(negedge clk);
    check("s6_flush_valid", o_valid, 1'b1);
    check("s6_flush_last", o_last, 1'b0);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("s6_rst_valid", o_valid, 1'b0);
    check("s6_rst_busy", o_busy, 1'b0);
    check("s6_rst_ready", o_ready, 1'b1);
    check("s6_rst_line_bits", o_line_bits, 16'd0);
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    send({{(CODE_MAX-8){1'b1}}, 8'hA5}, 8, 1'b1);
    expect_word("s6_new", 64'hA5, 8, 1'b1);
    @(negedge clk);
    check("s6_line_bits", o_line_bits, 16'd8);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
